// File: rtl/main_mem_line_ctrl_pkg.sv
// rtl/main_mem_line_ctrl_pkg.sv - shared line geometry, FSM states and request record
package main_mem_line_ctrl_pkg;

   localparam int ADDR_W     = 32;
   localparam int LINE_BYTES = 32;
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int LINE_W     = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_e;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/main_mem_line_ctrl_array.sv
// rtl/main_mem_line_ctrl_array.sv - synchronous 1R/1W line RAM with preload/peek access
module mem_line_array
   import main_mem_line_ctrl_pkg::*;
#(
   parameter int LINES = 2048,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [LINE_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [LINE_W-1:0] o_rd_data
);

   logic [LINE_W-1:0] r_mem [LINES];
   logic [LINE_W-1:0] r_rd_data;

   // Plain always so the preload task may also deposit into the array.
   always @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_idx];
      end
   end

   assign o_rd_data = r_rd_data;

   task automatic preload_line(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line);
      logic [IDX_W-1:0] idx;
      idx = IDX_W'(addr >> OFF_W);
      r_mem[idx] <= line;
   endtask

   task automatic peek_line(input logic [ADDR_W-1:0] addr, output logic [LINE_W-1:0] line);
      logic [IDX_W-1:0] idx;
      idx  = IDX_W'(addr >> OFF_W);
      line = r_mem[idx];
   endtask

endmodule

// File: rtl/main_mem_line_ctrl.sv
// rtl/main_mem_line_ctrl.sv - line-granular main memory controller with fixed access latency
module main_mem_line_ctrl
   import main_mem_line_ctrl_pkg::*;
#(
   parameter int MEM_LINES   = 2048,
   parameter int MEM_LATENCY = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_mem_req_valid,
   output logic              o_mem_req_ready,
   input  logic              i_mem_req_rw,
   input  logic [ADDR_W-1:0] i_mem_req_addr,
   input  logic [LINE_W-1:0] i_mem_req_wdata,
   output logic              o_mem_resp_valid,
   output logic [LINE_W-1:0] o_mem_resp_rdata,
   output logic              o_mem_resp_err,
   output logic [31:0]       o_rd_count,
   output logic [31:0]       o_wr_count
);

   localparam int IDX_W = $clog2(MEM_LINES);
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

   mem_state_e        r_state;
   mem_req_t          r_req;
   logic [CNT_W-1:0]  r_lat_cnt;
   logic              r_ready;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic              r_rd_ok;
   logic [31:0]       r_rd_count;
   logic [31:0]       r_wr_count;

   mem_req_t          w_cur;
   logic              w_accept;
   logic              w_enter_resp;
   logic              w_err;
   logic [IDX_W-1:0]  w_idx;
   logic              w_wr_en;
   logic              w_rd_en;
   logic [LINE_W-1:0] w_rd_data;

   assign w_accept = (r_state == IDLE) && i_mem_req_valid && r_ready;

   // With zero latency RESP is entered on the accept edge, so the live request is used.
   always_comb begin
      w_cur = r_req;
      if (r_state == IDLE) begin
         w_cur = '{rw: i_mem_req_rw, addr: i_mem_req_addr, wdata: i_mem_req_wdata};
      end
   end

   assign w_enter_resp = (w_accept && (MEM_LATENCY == 0)) ||
                         ((r_state == BUSY) && (r_lat_cnt == LAT_LAST));
   assign w_err   = |w_cur.addr[ADDR_W-1:OFF_W+IDX_W];
   assign w_idx   = w_cur.addr[OFF_W+IDX_W-1:OFF_W];
   assign w_wr_en = w_enter_resp && w_cur.rw && !w_err;
   assign w_rd_en = w_enter_resp && !w_cur.rw && !w_err;

   mem_line_array #(
      .LINES (MEM_LINES),
      .IDX_W (IDX_W)
   ) u_array (
      .i_clk     (i_clk),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_idx),
      .i_wr_data (w_cur.wdata),
      .i_rd_en   (w_rd_en),
      .i_rd_idx  (w_idx),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_req        <= '0;
         r_lat_cnt    <= '0;
         r_ready      <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_rd_ok      <= 1'b0;
         r_rd_count   <= 32'd0;
         r_wr_count   <= 32'd0;
      end else begin
         r_resp_valid <= w_enter_resp;
         if (w_enter_resp) begin
            r_resp_err <= w_err;
            r_rd_ok    <= w_rd_en;
            if (w_cur.rw) begin
               r_wr_count <= r_wr_count + 32'd1;
            end else begin
               r_rd_count <= r_rd_count + 32'd1;
            end
         end
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req     <= w_cur;
                  r_ready   <= 1'b0;
                  r_lat_cnt <= '0;
                  r_state   <= (MEM_LATENCY == 0) ? RESP : BUSY;
               end else begin
                  // One idle cycle with ready low separates consecutive transactions.
                  r_ready <= 1'b1;
               end
            end
            BUSY: begin
               if (r_lat_cnt == LAT_LAST) begin
                  r_state <= RESP;
               end else begin
                  r_lat_cnt <= r_lat_cnt + CNT_W'(1);
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_mem_req_ready  = r_ready;
   assign o_mem_resp_valid = r_resp_valid;
   assign o_mem_resp_rdata = r_rd_ok ? w_rd_data : '0;
   assign o_mem_resp_err   = r_resp_err;
   assign o_rd_count       = r_rd_count;
   assign o_wr_count       = r_wr_count;

endmodule

// File: tb/tb_main_mem_line_ctrl.sv
// tb/tb_main_mem_line_ctrl.sv - scoreboard bench for main_mem_line_ctrl (latency 5 and 0 builds)
module tb_main_mem_line_ctrl;

   localparam int LAT = 5;

   typedef struct {
      logic [255:0] data;
      logic         err;
      int           rd;
      int           wr;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         valid = 1'b0, rw = 1'b0;
   logic [31:0]  addr = '0;
   logic [255:0] wdata = '0;
   logic         ready, resp_valid, resp_err;
   logic [255:0] resp_rdata;
   logic [31:0]  rd_count, wr_count;

   logic         v0 = 1'b0, rw0 = 1'b0;
   logic [31:0]  addr0 = '0;
   logic [255:0] wdata0 = '0;
   logic         ready0, resp_valid0, resp_err0;
   logic [255:0] resp_rdata0;
   logic [31:0]  rd_count0, wr_count0;

   int   n_vec = 0, n_fail = 0, cyc = 0, m_rd = 0, m_wr = 0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   main_mem_line_ctrl #(.MEM_LINES(2048), .MEM_LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst(rst), .i_mem_req_valid(valid), .o_mem_req_ready(ready),
      .i_mem_req_rw(rw), .i_mem_req_addr(addr), .i_mem_req_wdata(wdata),
      .o_mem_resp_valid(resp_valid), .o_mem_resp_rdata(resp_rdata), .o_mem_resp_err(resp_err),
      .o_rd_count(rd_count), .o_wr_count(wr_count)
   );

   main_mem_line_ctrl #(.MEM_LINES(2048), .MEM_LATENCY(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_mem_req_valid(v0), .o_mem_req_ready(ready0),
      .i_mem_req_rw(rw0), .i_mem_req_addr(addr0), .i_mem_req_wdata(wdata0),
      .o_mem_resp_valid(resp_valid0), .o_mem_resp_rdata(resp_rdata0), .o_mem_resp_err(resp_err0),
      .o_rd_count(rd_count0), .o_wr_count(wr_count0)
   );

   function automatic logic [255:0] mk(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
      return l;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp", 256'(resp_valid), 256'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("resp_latency", 256'(cyc), 256'(mon_e.due));
            chk("resp_rdata", resp_rdata, mon_e.data);
            chk("resp_err", 256'(resp_err), 256'(mon_e.err));
            chk("rd_count", 256'(rd_count), 256'(mon_e.rd));
            chk("wr_count", 256'(wr_count), 256'(mon_e.wr));
         end
      end
   end

   task automatic issue(input logic i_rw, input logic [31:0] i_addr, input logic [255:0] i_wd,
                        input logic [255:0] exp_d, input logic exp_err, input bit track);
      int n;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         chk("ready_timeout", 256'(ready), 256'd1);
         return;
      end
      valid = 1'b1; rw = i_rw; addr = i_addr; wdata = i_wd;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      if (track) begin
         if (i_rw) m_wr++; else m_rd++;
         sb.push_back('{data: exp_d, err: exp_err, rd: m_rd, wr: m_wr, due: cyc + LAT});
      end
      chk("ready_drop", 256'(ready), 256'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) chk("drain_timeout", 256'(sb.size()), 256'd0);
   endtask

   logic [255:0] pk;

   initial begin
      #1 rst = 1'b1;
      #3;
      chk("rst_ready", 256'(ready), 256'd1);
      chk("rst_resp_valid", 256'(resp_valid), 256'd0);
      chk("rst_rdata", resp_rdata, 256'd0);
      chk("rst_err", 256'(resp_err), 256'd0);
      chk("rst_counts", 256'({rd_count, wr_count}), 256'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      dut.u_array.preload_line(32'h40, mk(32'h11110000));
      dut.u_array.preload_line(32'h0, mk(32'hDEAD0000));
      dut.u_array.preload_line(32'h20, mk(32'h0D0D0000));
      @(negedge clk);

      issue(1'b0, 32'h44, '0, mk(32'h11110000), 1'b0, 1'b1);
      issue(1'b1, 32'h1044, mk(32'hA5A50000), '0, 1'b0, 1'b1);
      issue(1'b0, 32'h1044, '0, mk(32'hA5A50000), 1'b0, 1'b1);
      drain();
      dut.u_array.peek_line(32'h1040, pk);
      chk("peek_1040", pk, mk(32'hA5A50000));

      issue(1'b0, 32'h0001_0000, '0, '0, 1'b1, 1'b1);
      issue(1'b1, 32'h0001_0000, mk(32'hBEEF0000), '0, 1'b1, 1'b1);
      drain();
      dut.u_array.peek_line(32'h0, pk);
      chk("peek_idx0_unchanged", pk, mk(32'hDEAD0000));

      issue(1'b1, 32'h20, mk(32'hE0E00000), '0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", 256'(ready), 256'd1);
      chk("midrst_resp_valid", 256'(resp_valid), 256'd0);
      chk("midrst_counts", 256'({rd_count, wr_count}), 256'd0);
      m_rd = 0; m_wr = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      dut.u_array.peek_line(32'h20, pk);
      chk("peek_20_old", pk, mk(32'h0D0D0000));
      issue(1'b0, 32'h20, '0, mk(32'h0D0D0000), 1'b0, 1'b1);
      drain();

      dut0.u_array.preload_line(32'h60, mk(32'h60600000));
      @(negedge clk);
      chk("lat0_ready_idle", 256'(ready0), 256'd1);
      v0 = 1'b1; rw0 = 1'b0; addr0 = 32'h64;
      @(negedge clk);
      v0 = 1'b0;
      chk("lat0_resp_valid", 256'(resp_valid0), 256'd1);
      chk("lat0_rdata", resp_rdata0, mk(32'h60600000));
      chk("lat0_err", 256'(resp_err0), 256'd0);
      chk("lat0_ready_low1", 256'(ready0), 256'd0);
      @(negedge clk);
      chk("lat0_resp_pulse", 256'(resp_valid0), 256'd0);
      chk("lat0_ready_low2", 256'(ready0), 256'd0);
      @(negedge clk);
      chk("lat0_ready_back", 256'(ready0), 256'd1);
      chk("lat0_rd_count", 256'(rd_count0), 256'd1);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
